tweak_schedule: RTL and testbench
=================================

// Module: tweak_schedule
// PURPOSE
//  Generates the Skein UBI tweak (T0, T1, T2 = T0^T1) for each 128-byte Threefish-1024 block, and steps
//  the key-schedule subkey index s. Drives tweak_o and the two mod-3 word selects
//  (s mod 3, (s+1) mod 3) consumed by the downstream tweak word select muxes during key injection.
//  Sits between the UBI block controller (start/next) and the subkey adder datapath.
// PARAMETERS
//  NUM_SUBKEYS  21  subkeys per block (Threefish-1024: 80 rounds / 4 + 1)
//  POS_WIDTH    96  width of the byte-position counter (Skein tweak bits 95:0)
// PORTS
//  clk           in   1    system clock
//  rst           in   1    synchronous reset, active high
//  clear_i       in   1    zero position counter (new message); honoured only in IDLE
//  start_i       in   1    begin tweak for a new block; honoured only in IDLE
//  byte_count_i  in   8    bytes consumed by this block, 0..128
//  type_i        in   6    UBI type field (e.g. 6'd48 = message)
//  first_i       in   1    first-block flag for this block
//  final_i       in   1    final-block flag for this block
//  next_i        in   1    subkey consumed; advance s (RUN only)
//  tweak_o       out  192  {T2,T1,T0}; T0 = [63:0], T1 = [127:64], T2 = [191:128]
//  sel_a_o       out  2    s mod 3, values 0..2 only
//  sel_b_o       out  2    (s+1) mod 3, values 0..2 only
//  subkey_idx_o  out  5    current s, 0..NUM_SUBKEYS-1
//  busy_o        out  1    high in RUN
//  done_o        out  1    one-cycle pulse after last subkey consumed
// BEHAVIOUR
//  Reset: position=0, tweak_o=0, sel_a_o=0, sel_b_o=1, subkey_idx_o=0, busy_o=0, done_o=0, state IDLE.
//  States: IDLE -> (start_i) RUN -> (next_i at s==NUM_SUBKEYS-1) DONE -> IDLE (unconditional, 1 cycle).
//  IDLE: clear_i sets position=0. start_i (cycle N): position += byte_count_i (mod 2^POS_WIDTH);
//   flags latched; s=0, sel_a=0, sel_b=1. Cycle N+1: new tweak_o valid, busy_o=1, state RUN.
//   clear_i and start_i together: clear applies first, i.e. position = byte_count_i.
//  Tweak layout: T0 = position[63:0]; T1[31:0] = position[95:64]; T1[55:32] = 0;
//   T1[61:56] = type; T1[62] = first; T1[63] = final; T2 = T0 ^ T1. Registered, stable outside IDLE->RUN edge.
//  RUN: next_i increments s; sel_a/sel_b are mod-3 counters (2->0 wrap, no divider), always sel_b = sel_a+1 mod 3.
//   next_i at s==NUM_SUBKEYS-1: s holds, state DONE, done_o=1 next cycle, busy_o=0.
//   start_i/clear_i in RUN or DONE: ignored (no state or position change).
//  DONE: done_o high exactly one cycle; next_i ignored; tweak_o and position retained for the next block.
//  rst mid-RUN: all state returns to reset values next cycle; no done_o pulse.
//  byte_count_i > 128 is illegal input; behaviour unspecified.
// TESTING
//  1 rst held 2 cycles -> tweak_o=0, sel_a_o=0, sel_b_o=1, busy_o=0, done_o=0.
//  2 clear; start bc=128 type=48 first=1 final=0 -> T0=0x80, T1=0x7000_0000_0000_0000,
//    T2=0x7000_0000_0000_0080, busy_o=1 one cycle after start.
//  3 21 next_i pulses -> subkey_idx 0..20, sel_a 0,1,2,0..; sel_b 1,2,0,..;
//    done_o single pulse the cycle after 21st next, busy_o=0.
//  4 then start bc=64 type=48 first=0 final=1 -> T0=0xC0, T1=0xB000_0000_0000_0000, T2=0xB000_0000_0000_00C0.
//  5 start_i and clear_i pulsed mid-RUN -> tweak_o, s unchanged; rst at s=7 -> reset values, no done_o.
//  6 clear+start same cycle bc=0 first=1 final=1 -> T0=0, T1=0xF000_0000_0000_0000 (type 48).

Source files
------------

// File: rtl/tweak_schedule.sv
// Skein UBI tweak generator and Threefish-1024 subkey index stepper.
// Latency: tweak/s valid one cycle after start_i; done_o one cycle after the last next_i.
// Backpressure: none; start_i/clear_i are dropped outside IDLE, next_i is dropped outside RUN.
module tweak_schedule #(
    parameter int NUM_SUBKEYS = 21,
    parameter int POS_WIDTH   = 96
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         start_i,
    input  logic [7:0]   byte_count_i,
    input  logic [5:0]   type_i,
    input  logic         first_i,
    input  logic         final_i,
    input  logic         next_i,
    output logic [191:0] tweak_o,
    output logic [1:0]   sel_a_o,
    output logic [1:0]   sel_b_o,
    output logic [4:0]   subkey_idx_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST_S = 5'(NUM_SUBKEYS - 1);

    state_t                 state, state_nxt;
    logic [POS_WIDTH-1:0]   position, position_nxt;
    logic [191:0]           tweak, tweak_nxt;
    logic [4:0]             s, s_nxt;
    logic [1:0]             sel_a, sel_a_nxt;
    logic [1:0]             sel_b, sel_b_nxt;

    // Packs {T2,T1,T0}: T1 carries the position high word, type and the first/final flags.
    function automatic logic [191:0] build_tweak(
        input logic [POS_WIDTH-1:0] pos,
        input logic [5:0]           typ,
        input logic                 first,
        input logic                 fin
    );
        logic [63:0] t0;
        logic [63:0] t1;
        t0 = pos[63:0];
        t1 = {fin, first, typ, 24'd0, pos[95:64]};
        return {t0 ^ t1, t1, t0};
    endfunction

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            position <= '0;
            tweak    <= '0;
            s        <= 5'd0;
            sel_a    <= 2'd0;
            sel_b    <= 2'd1;
        end else begin
            state    <= state_nxt;
            position <= position_nxt;
            tweak    <= tweak_nxt;
            s        <= s_nxt;
            sel_a    <= sel_a_nxt;
            sel_b    <= sel_b_nxt;
        end
    end

    // Next-state logic: block setup in IDLE, subkey stepping in RUN, one-cycle DONE.
    always_comb begin
        state_nxt    = state;
        position_nxt = position;
        tweak_nxt    = tweak;
        s_nxt        = s;
        sel_a_nxt    = sel_a;
        sel_b_nxt    = sel_b;
        unique case (state)
            IDLE: begin
                // Clear takes effect before the start accumulation in the same cycle.
                if (clear_i) begin
                    position_nxt = '0;
                end
                if (start_i) begin
                    position_nxt = position_nxt + {{(POS_WIDTH-8){1'b0}}, byte_count_i};
                    tweak_nxt    = build_tweak(position_nxt, type_i, first_i, final_i);
                    s_nxt        = 5'd0;
                    sel_a_nxt    = 2'd0;
                    sel_b_nxt    = 2'd1;
                    state_nxt    = RUN;
                end
            end
            RUN: begin
                if (next_i) begin
                    if (s == LAST_S) begin
                        state_nxt = DONE;
                    end else begin
                        // Mod-3 selects step alongside s, wrapping 2->0 without a divider.
                        s_nxt     = s + 5'd1;
                        sel_a_nxt = (sel_a == 2'd2) ? 2'd0 : sel_a + 2'd1;
                        sel_b_nxt = (sel_b == 2'd2) ? 2'd0 : sel_b + 2'd1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign tweak_o      = tweak;
    assign sel_a_o      = sel_a;
    assign sel_b_o      = sel_b;
    assign subkey_idx_o = s;
    assign busy_o       = (state == RUN);
    assign done_o       = (state == DONE);

endmodule

// File: tb/tb_tweak_schedule.sv
module tb_tweak_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear_i;
    logic         start_i;
    logic [7:0]   byte_count_i;
    logic [5:0]   type_i;
    logic         first_i;
    logic         final_i;
    logic         next_i;
    logic [191:0] tweak_o;
    logic [1:0]   sel_a_o;
    logic [1:0]   sel_b_o;
    logic [4:0]   subkey_idx_o;
    logic         busy_o;
    logic         done_o;

    int errors = 0;
    int checks = 0;

    // reference model
    logic [95:0]  m_pos;
    logic [191:0] m_tweak;
    int           m_s;
    bit           m_busy;
    bit           m_done;

    tweak_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear_i),
        .start_i      (start_i),
        .byte_count_i (byte_count_i),
        .type_i       (type_i),
        .first_i      (first_i),
        .final_i      (final_i),
        .next_i       (next_i),
        .tweak_o      (tweak_o),
        .sel_a_o      (sel_a_o),
        .sel_b_o      (sel_b_o),
        .subkey_idx_o (subkey_idx_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    function automatic logic [191:0] ref_tweak(input logic [95:0] pos, input logic [5:0] typ,
                                               input bit first, input bit fin);
        logic [63:0] t0;
        logic [63:0] t1;
        t0 = pos[63:0];
        t1 = 64'(pos >> 64) | (64'(typ) << 56) | (64'(first) << 62) | (64'(fin) << 63);
        return {t0 ^ t1, t1, t0};
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("tweak", tweak_o, m_tweak);
        chk("sel_a", 192'(sel_a_o), 192'(m_s % 3));
        chk("sel_b", 192'(sel_b_o), 192'((m_s + 1) % 3));
        chk("subkey_idx", 192'(subkey_idx_o), 192'(m_s));
        chk("busy", 192'(busy_o), 192'(m_busy));
        chk("done", 192'(done_o), 192'(m_done));
    endtask

    // Advance the model with the currently driven inputs, clock the DUT, then compare.
    task automatic cyc();
        if (rst) begin
            m_pos = '0; m_tweak = '0; m_s = 0; m_busy = 0; m_done = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_busy) begin
            if (next_i) begin
                if (m_s == 20) begin
                    m_busy = 0;
                    m_done = 1;
                end else begin
                    m_s++;
                end
            end
        end else begin
            if (clear_i) m_pos = '0;
            if (start_i) begin
                m_pos   = m_pos + 96'(byte_count_i);
                m_tweak = ref_tweak(m_pos, type_i, first_i, final_i);
                m_s     = 0;
                m_busy  = 1;
            end
        end
        @(posedge clk);
        #1;
        chk_all();
        rst = 0; clear_i = 0; start_i = 0; next_i = 0;
    endtask

    task automatic start_blk(input logic [7:0] bc, input logic [5:0] typ, input bit f, input bit fin,
                             input bit clr);
        clear_i = clr; start_i = 1; byte_count_i = bc; type_i = typ; first_i = f; final_i = fin;
        cyc();
    endtask

    task automatic nexts(input int n);
        for (int i = 0; i < n; i++) begin
            next_i = 1;
            cyc();
        end
    endtask

    initial begin
        rst = 1; clear_i = 0; start_i = 0; next_i = 0;
        byte_count_i = 0; type_i = 0; first_i = 0; final_i = 0;
        m_pos = '0; m_tweak = '0; m_s = 0; m_busy = 0; m_done = 0;

        // reset held two cycles
        rst = 1; cyc();
        rst = 1; cyc();
        chk("reset_sel_b_const", 192'(sel_b_o), 192'd1);
        chk("reset_tweak_const", tweak_o, 192'd0);

        // first message block
        clear_i = 1; cyc();
        start_blk(8'd128, 6'd48, 1, 0, 0);
        chk("blk1_tweak_const", tweak_o,
            {64'h7000_0000_0000_0080, 64'h7000_0000_0000_0000, 64'h0000_0000_0000_0080});
        chk("blk1_busy_const", 192'(busy_o), 192'd1);
        nexts(21);
        chk("blk1_done_const", 192'(done_o), 192'd1);
        chk("blk1_done_idx", 192'(subkey_idx_o), 192'd20);
        start_i = 1; clear_i = 1; byte_count_i = 8'd77;  // ignored in DONE
        cyc();
        chk("blk1_done_drop", 192'(done_o), 192'd0);

        // second block, position accumulates
        start_blk(8'd64, 6'd48, 0, 1, 0);
        chk("blk2_tweak_const", tweak_o,
            {64'hB000_0000_0000_00C0, 64'hB000_0000_0000_0000, 64'h0000_0000_0000_00C0});
        nexts(3);
        start_i = 1; clear_i = 1; byte_count_i = 8'd5; type_i = 6'd1;
        cyc();
        nexts(4);
        chk("blk2_s7", 192'(subkey_idx_o), 192'd7);
        rst = 1; cyc();
        cyc();
        cyc();

        // clear and start in the same cycle
        start_blk(8'd0, 6'd48, 1, 1, 1);
        chk("blk3_tweak_const", tweak_o, {64'hF000_0000_0000_0000, 64'hF000_0000_0000_0000, 64'd0});
        nexts(21);
        cyc();

        // randomized blocks
        for (int b = 0; b < 40; b++) begin
            int idle = $urandom_range(0, 3);
            int budget;
            for (int k = 0; k < idle; k++) begin
                clear_i = ($urandom_range(0, 3) == 0);
                cyc();
            end
            start_blk(8'($urandom_range(0, 128)), 6'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 4) == 0));
            budget = 0;
            while (m_busy || m_done) begin
                next_i       = 1'($urandom);
                start_i      = ($urandom_range(0, 5) == 0);
                clear_i      = ($urandom_range(0, 5) == 0);
                byte_count_i = 8'($urandom_range(0, 128));
                cyc();
                budget++;
                if (budget > 400) begin
                    chk("block_timeout", 192'(budget), 192'd0);
                    break;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
